spi_word_rx: RTL and testbench

SPI_WORD_RX -- requirements
Module: spi_word_rx

---
 rtl/spi_word_rx_if.sv | 34 +++
 rtl/spi_word_rx.sv | 184 ++++++++++++++++++
 tb/tb_spi_word_rx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_word_rx_if.sv
// -----------------------------------------------------------------------------
// spi_word_rx_if
// SPI bus bundle between an external SPI master and the spi_word_rx receiver.
//
// Signals:
//   spi_sck     SPI clock driven by the master (CPOL=0, CPHA=0)
//   spi_mosi    data from master to slave, MSB first
//   spi_ssel_n  active-low chip select driven by the master
//   spi_miso    data from slave back to the master
//
// Modports:
//   master  drives sck/mosi/ssel_n, reads miso
//   slave   reads sck/mosi/ssel_n, drives miso
// -----------------------------------------------------------------------------
interface spi_word_rx_if;
    logic spi_sck;
    logic spi_mosi;
    logic spi_ssel_n;
    logic spi_miso;

    modport master (
        output spi_sck,
        output spi_mosi,
        output spi_ssel_n,
        input  spi_miso
    );

    modport slave (
        input  spi_sck,
        input  spi_mosi,
        input  spi_ssel_n,
        output spi_miso
    );
endinterface

// File: rtl/spi_word_rx.sv
// -----------------------------------------------------------------------------
// spi_word_rx
// SPI slave word receiver (CPOL=0, CPHA=0) oversampled by clk25M. The raw SPI
// pins are synchronized into the clk25M domain, edges are detected there, and
// complete WORD_BITS words are handed to the PWM stage with a one-cycle strobe.
// While receiving, the previously completed word is echoed back on MISO.
//
// Parameters:
//   WORD_BITS    bits per received word, MSB first (>= 2)
//   SYNC_STAGES  flop depth of each input synchronizer (2..3)
//
// Ports:
//   clk25M              system clock; the only clock domain of this block
//   rst_n               asynchronous active-low reset
//   spi                 SPI bus (slave modport): sck, mosi, ssel_n in, miso out
//   byte_data_received  last complete word ([15:8] channel, [7:0] duty)
//   SSEL                one-cycle strobe per complete word
//   frame_active        high while the chip select is (synchronously) asserted
//   frame_err           one-cycle pulse when a frame ends on a partial word
//   word_count          complete words since reset, modulo 256
// -----------------------------------------------------------------------------
module spi_word_rx #(
    parameter int WORD_BITS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk25M,
    input  logic                 rst_n,
    spi_word_rx_if.slave         spi,
    output logic [WORD_BITS-1:0] byte_data_received,
    output logic                 SSEL,
    output logic                 frame_active,
    output logic                 frame_err,
    output logic [7:0]           word_count
);

    localparam int CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ssel_sync;
    logic                   sck_prev;
    logic                   ssel_prev;

    logic sck_s;
    logic mosi_s;
    logic ssel_s;
    logic sck_rise;
    logic sck_fall;
    logic ssel_rise;
    logic ssel_fall;

    logic [0:0]           state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [WORD_BITS-1:0] shift_reg;
    logic [WORD_BITS-1:0] tx_reg;
    logic [WORD_BITS-1:0] next_word;
    logic                 word_done;
    logic                 last_bit_rise;

    // Pin synchronizers plus one edge-history flop per edge-detected signal.
    // The chip-select chain, including its history flop, resets to the
    // deasserted level so that leaving reset never looks like an ssel edge.
    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ssel_sync <= '1;
            sck_prev  <= 1'b0;
            ssel_prev <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0],  spi.spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.spi_mosi};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], spi.spi_ssel_n};
            sck_prev  <= sck_s;
            ssel_prev <= ssel_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ssel_s = ssel_sync[SYNC_STAGES-1];

    assign sck_rise  =  sck_s  & ~sck_prev;
    assign sck_fall  = ~sck_s  &  sck_prev;
    assign ssel_rise =  ssel_s & ~ssel_prev;
    assign ssel_fall = ~ssel_s &  ssel_prev;

    // The word as it will look once the current MOSI bit is shifted in.
    assign next_word     = {shift_reg[WORD_BITS-2:0], mosi_s};
    assign last_bit_rise = (state == SHIFT) && sck_rise && (bit_cnt == LAST_BIT);

    // Frame state: a frame opens on ssel fall and closes on ssel rise.
    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            if (ssel_fall) begin
                state <= SHIFT;
            end
        end else begin
            if (ssel_rise) begin
                state <= IDLE;
            end
        end
    end

    // Receive shifter and bit counter. A completing SCK rise wins over a
    // simultaneous ssel rise, so that word still completes without an error.
    // word_done registers the completion; the output stage acts one cycle on.
    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_done <= 1'b0;
            frame_err <= 1'b0;
            if (ssel_fall) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (state == SHIFT) begin
                if (sck_rise) begin
                    shift_reg <= next_word;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt   <= '0;
                        word_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (ssel_rise && !last_bit_rise) begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                    if (bit_cnt != '0) begin
                        frame_err <= 1'b1;
                    end
                end
            end
        end
    end

    // Word output stage: publish the completed word, strobe, and count.
    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            byte_data_received <= '0;
            SSEL               <= 1'b0;
            word_count         <= 8'd0;
        end else begin
            SSEL <= word_done;
            if (word_done) begin
                byte_data_received <= shift_reg;
                word_count         <= word_count + 8'd1;
            end
        end
    end

    // Echo transmitter. The word completed by the last SCK rise is loaded
    // straight away so its MSB is already on MISO when the trailing SCK fall
    // arrives; that fall (bit counter back at 0) must not shift, because it
    // is the edge that presents the MSB for the next word. If a completion
    // is still in flight when a new frame opens, that word is the newest one.
    always_ff @(posedge clk25M or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg <= '0;
        end else if (ssel_fall) begin
            tx_reg <= word_done ? shift_reg : byte_data_received;
        end else if (state == SHIFT) begin
            if (last_bit_rise) begin
                tx_reg <= next_word;
            end else if (sck_fall && (bit_cnt != '0)) begin
                tx_reg <= {tx_reg[WORD_BITS-2:0], 1'b0};
            end
        end
    end

    assign frame_active = (state == SHIFT);
    assign spi.spi_miso = (state == SHIFT) ? tx_reg[WORD_BITS-1] : 1'b0;

endmodule

// File: tb/tb_spi_word_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_word_rx
// Self-checking bench for spi_word_rx. An SPI master model drives the bus at
// clk25M/8; every full word it sends is pushed to a scoreboard queue, and a
// monitor pops and checks it (value and strobe latency) on each SSEL pulse.
// -----------------------------------------------------------------------------
module tb_spi_word_rx;

    logic        clk25M;
    logic        rst_n;
    logic [15:0] byte_data_received;
    logic        SSEL;
    logic        frame_active;
    logic        frame_err;
    logic [7:0]  word_count;

    spi_word_rx_if bus ();

    spi_word_rx #(
        .WORD_BITS   (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk25M             (clk25M),
        .rst_n              (rst_n),
        .spi                (bus),
        .byte_data_received (byte_data_received),
        .SSEL               (SSEL),
        .frame_active       (frame_active),
        .frame_err          (frame_err),
        .word_count         (word_count)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    int          cycle   = 0;
    int          lastRiseCycle = 0;
    int          wordsSent = 0;
    int          nFrameErr = 0;
    logic        prevSsel = 1'b0;
    logic [15:0] expQ [$];

    // 25 MHz system clock
    initial begin
        clk25M = 1'b0;
        forever #20 clk25M = ~clk25M;
    end

    always @(posedge clk25M) cycle++;

    // Watchdog so the run always ends
    initial begin
        #10ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard monitor, sampled on the falling clock edge
    always @(negedge clk25M) begin
        logic [15:0] expWord;
        if (frame_err) nFrameErr++;
        if (SSEL) begin
            checkOutput("SSEL width", prevSsel, 1'b0);
            checkOutput("SSEL latency", cycle - lastRiseCycle, 4);
            checkOutput("scoreboard has entry", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                expWord = expQ.pop_front();
                checkOutput("received word", byte_data_received, expWord);
            end
        end
        prevSsel = SSEL;
    end

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk25M);
    endtask

    // Send nbits of word MSB first; capture MISO just before each rising edge.
    // With closeOnLast, ssel_n rises together with the final SCK rise.
    task automatic applyStimulus(input logic [15:0] word, input int nbits,
                                 input bit closeOnLast, output logic [15:0] misoWord);
        misoWord = '0;
        if (nbits == 16) begin
            expQ.push_back(word);
            wordsSent++;
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk25M);
            bus.spi_mosi = word[15 - (i % 16)];
            waitClocks(3);
            misoWord = {misoWord[14:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            if (closeOnLast && i == nbits - 1) bus.spi_ssel_n = 1'b1;
            lastRiseCycle = cycle;
            waitClocks(4);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic startFrame();
        bus.spi_ssel_n = 1'b0;
        waitClocks(8);
    endtask

    task automatic endFrame();
        waitClocks(8);
        bus.spi_ssel_n = 1'b1;
        waitClocks(8);
    endtask

    initial begin
        logic [15:0] miso;
        int          errBefore;

        rst_n          = 1'b0;
        bus.spi_sck    = 1'b0;
        bus.spi_mosi   = 1'b0;
        bus.spi_ssel_n = 1'b1;
        waitClocks(4);

        // Reset state
        checkOutput("reset data", byte_data_received, 16'h0000);
        checkOutput("reset SSEL", SSEL, 1'b0);
        checkOutput("reset word_count", word_count, 8'd0);
        checkOutput("reset frame_err", frame_err, 1'b0);
        checkOutput("reset frame_active", frame_active, 1'b0);
        checkOutput("reset miso", bus.spi_miso, 1'b0);
        rst_n = 1'b1;
        waitClocks(10);
        checkOutput("post-release frame_active", frame_active, 1'b0);
        checkOutput("post-release frame_err count", nFrameErr, 0);
        checkOutput("post-release word_count", word_count, 8'd0);

        // SCK toggling with chip select high is ignored
        $display("[TB] SCK toggles with ssel high");
        applyStimulus(16'hFFFF, 20, 1'b0, miso);
        waitClocks(8);
        checkOutput("idle sck miso", miso, 16'h0000);
        checkOutput("idle sck word_count", word_count, 8'd0);
        checkOutput("idle sck frame_active", frame_active, 1'b0);

        // Single word frame
        $display("[TB] single word 0380");
        startFrame();
        checkOutput("frame_active in frame", frame_active, 1'b1);
        applyStimulus(16'h0380, 16, 1'b0, miso);
        checkOutput("first frame miso echo", miso, 16'h0000);
        endFrame();
        checkOutput("0380 data", byte_data_received, 16'h0380);
        checkOutput("0380 word_count", word_count, 8'(wordsSent));
        checkOutput("0380 frame_err count", nFrameErr, 0);
        checkOutput("frame_active after frame", frame_active, 1'b0);

        // Two words in one frame, echo of the previous word on MISO
        $display("[TB] two words 0211, 01FF");
        startFrame();
        applyStimulus(16'h0211, 16, 1'b0, miso);
        checkOutput("word1 miso echo", miso, 16'h0380);
        applyStimulus(16'h01FF, 16, 1'b0, miso);
        checkOutput("word2 miso echo", miso, 16'h0211);
        endFrame();
        checkOutput("two word data", byte_data_received, 16'h01FF);
        checkOutput("two word word_count", word_count, 8'(wordsSent));

        // Partial frame after a good word
        $display("[TB] abort after 9 bits");
        startFrame();
        applyStimulus(16'h0155, 16, 1'b0, miso);
        endFrame();
        errBefore = nFrameErr;
        startFrame();
        applyStimulus(16'hABCD, 9, 1'b0, miso);
        checkOutput("partial miso echo", miso, 16'h0002);
        endFrame();
        checkOutput("partial frame_err pulses", nFrameErr - errBefore, 1);
        checkOutput("partial data held", byte_data_received, 16'h0155);
        checkOutput("partial word_count", word_count, 8'(wordsSent));

        // Chip select rising together with the completing SCK rise
        $display("[TB] ssel rise on final sck rise");
        errBefore = nFrameErr;
        startFrame();
        applyStimulus(16'h02C3, 16, 1'b1, miso);
        waitClocks(12);
        checkOutput("coincident frame_err", nFrameErr - errBefore, 0);
        checkOutput("coincident data", byte_data_received, 16'h02C3);
        checkOutput("coincident frame_active", frame_active, 1'b0);

        // Reset in the middle of a frame
        $display("[TB] reset mid-frame");
        errBefore = nFrameErr;
        startFrame();
        applyStimulus(16'h5A5A, 8, 1'b0, miso);
        rst_n = 1'b0;
        bus.spi_ssel_n = 1'b1;
        wordsSent = 0;
        waitClocks(4);
        checkOutput("mid reset data", byte_data_received, 16'h0000);
        checkOutput("mid reset word_count", word_count, 8'd0);
        rst_n = 1'b1;
        waitClocks(8);
        checkOutput("after reset frame_active", frame_active, 1'b0);
        startFrame();
        applyStimulus(16'h03AA, 16, 1'b0, miso);
        checkOutput("after reset miso echo", miso, 16'h0000);
        endFrame();
        checkOutput("reset frame frame_err", nFrameErr - errBefore, 0);
        checkOutput("reset frame data", byte_data_received, 16'h03AA);
        checkOutput("reset frame word_count", word_count, 8'd1);

        // word_count wrap after 256 words
        $display("[TB] word_count wrap");
        errBefore = nFrameErr;
        startFrame();
        for (int w = 0; w < 254; w++) begin
            applyStimulus(16'($urandom), 16, 1'b0, miso);
        end
        waitClocks(8);
        checkOutput("count before wrap", word_count, 8'd255);
        applyStimulus(16'h1234, 16, 1'b0, miso);
        endFrame();
        checkOutput("count wrapped", word_count, 8'(wordsSent % 256));
        checkOutput("wrap data", byte_data_received, 16'h1234);
        checkOutput("wrap frame_err", nFrameErr - errBefore, 0);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
